// File: rtl/dpll_pkg.sv
// rtl/dpll_pkg.sv - shared types, defaults and saturation helpers for the DPLL
// Contents: PFD state type, default centre word and tuning span, signed clamp helpers.
package dpll_pkg;

    typedef enum logic [1:0] {IDLE, LEAD, LAG, UPDATE} pfd_state_t;

    localparam logic [31:0] F0_WORD_DEF = 32'h001A36E3;
    localparam logic [31:0] FSPAN_DEF   = 32'h00020000;

    // Helpers work on a fixed wide signed type; callers sign-extend into it.
    localparam int WIDE_W = 64;

    function automatic logic signed [WIDE_W-1:0] clamp_s(
        input logic signed [WIDE_W-1:0] v,
        input logic signed [WIDE_W-1:0] lo,
        input logic signed [WIDE_W-1:0] hi
    );
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic logic signed [WIDE_W-1:0] sat_sym(
        input logic signed [WIDE_W-1:0] v,
        input logic signed [WIDE_W-1:0] lim
    );
        return clamp_s(v, -lim, lim);
    endfunction

endpackage

// File: rtl/dpll_pfd.sv
// rtl/dpll_pfd.sv - clk-synchronous phase/frequency detector with cycle-count error
// Ports: clk, nrst (sync, active-high), enable, link (async ref), nco_edge (NCO rising strobe),
//        err (signed, + = reference leads), err_vld (1-cycle strobe), up, dn (counting flags).
module dpll_pfd
    import dpll_pkg::*;
#(
    parameter int ERR_W = 16
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    enable,
    input  logic                    link,
    input  logic                    nco_edge,
    output logic signed [ERR_W-1:0] err,
    output logic                    err_vld,
    output logic                    up,
    output logic                    dn
);

    // Largest positive error; a measurement reaching it is closed as a timeout.
    localparam logic [ERR_W-1:0] CNT_MAX = {1'b0, {(ERR_W-1){1'b1}}};

    // [0],[1]: two-flop synchroniser; [2]: history for rising-edge detect.
    logic [2:0]       link_sync;
    logic             ref_edge;
    pfd_state_t       state;
    logic [ERR_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (nrst) link_sync <= '0;
        else      link_sync <= {link_sync[1:0], link};
    end

    assign ref_edge = link_sync[1] & ~link_sync[2];

    always_ff @(posedge clk) begin
        if (nrst) begin
            state   <= IDLE;
            cnt     <= '0;
            err     <= '0;
            err_vld <= 1'b0;
            up      <= 1'b0;
            dn      <= 1'b0;
        end else if (!enable) begin
            // Any measurement in progress is abandoned; err keeps its last value.
            state   <= IDLE;
            cnt     <= '0;
            err_vld <= 1'b0;
            up      <= 1'b0;
            dn      <= 1'b0;
        end else begin
            err_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (ref_edge && nco_edge) begin
                        err     <= '0;
                        err_vld <= 1'b1;
                        state   <= UPDATE;
                    end else if (ref_edge) begin
                        cnt   <= ERR_W'(1);
                        up    <= 1'b1;
                        state <= LEAD;
                    end else if (nco_edge) begin
                        cnt   <= ERR_W'(1);
                        dn    <= 1'b1;
                        state <= LAG;
                    end
                end
                LEAD: begin
                    // A repeated reference edge here is deliberately ignored.
                    if (nco_edge || cnt == CNT_MAX) begin
                        err     <= $signed(cnt);
                        err_vld <= 1'b1;
                        up      <= 1'b0;
                        state   <= UPDATE;
                    end else begin
                        cnt <= cnt + ERR_W'(1);
                    end
                end
                LAG: begin
                    if (ref_edge || cnt == CNT_MAX) begin
                        err     <= -$signed(cnt);
                        err_vld <= 1'b1;
                        dn      <= 1'b0;
                        state   <= UPDATE;
                    end else begin
                        cnt <= cnt + ERR_W'(1);
                    end
                end
                // Edges landing in this cycle are dropped.
                UPDATE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dpll_nco_loop.sv
// rtl/dpll_nco_loop.sv - all-digital PLL: PFD, PI loop filter, clamped NCO, optional lock detect
// Ports: clk, nrst (sync, active-high), enable (loop run), link (async ref),
//        f (tuning word), vco (NCO MSB), up, dn, err, err_vld, locked.
// Build option: DPLL_LOCK_DETECT_EN enables the lock detector; otherwise locked is tied 0.
module dpll_nco_loop
    import dpll_pkg::*;
#(
    parameter int               ACC_W    = 32,
    parameter int               ERR_W    = 16,
    parameter logic [ACC_W-1:0] F0_WORD  = F0_WORD_DEF,
    parameter logic [ACC_W-1:0] FSPAN    = FSPAN_DEF,
    parameter int               KP       = 64,
    parameter int               KI       = 4,
    parameter int               LOCK_TOL = 2,
    parameter int               LOCK_CNT = 8
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    enable,
    input  logic                    link,
    output logic [ACC_W-1:0]        f,
    output logic                    vco,
    output logic                    up,
    output logic                    dn,
    output logic signed [ERR_W-1:0] err,
    output logic                    err_vld,
    output logic                    locked
);

    // Filter arithmetic width: two headroom bits over the accumulator.
    localparam int W = ACC_W + 2;
    localparam logic signed [W-1:0] KP_X    = W'(KP);
    localparam logic signed [W-1:0] KI_X    = W'(KI);
    localparam logic signed [W-1:0] F0_X    = $signed({2'b00, F0_WORD});
    localparam logic signed [W-1:0] FSPAN_X = $signed({2'b00, FSPAN});

    logic [ACC_W-1:0]    acc;
    logic                vco_d;
    logic                nco_edge;
    logic signed [W-1:0] err_x;
    logic signed [W-1:0] integ;
    logic signed [W-1:0] integ_c;
    logic [ACC_W-1:0]    f_c;

    // NCO keeps running regardless of enable.
    always_ff @(posedge clk) begin
        if (nrst) begin
            acc   <= '0;
            vco_d <= 1'b0;
        end else begin
            acc   <= acc + f;
            vco_d <= acc[ACC_W-1];
        end
    end

    assign vco      = acc[ACC_W-1];
    assign nco_edge = vco & ~vco_d;

    dpll_pfd #(.ERR_W(ERR_W)) u_pfd (
        .clk      (clk),
        .nrst     (nrst),
        .enable   (enable),
        .link     (link),
        .nco_edge (nco_edge),
        .err      (err),
        .err_vld  (err_vld),
        .up       (up),
        .dn       (dn)
    );

    // PI filter: the integrator is clamped to the span so it cannot wind up past what f can use.
    assign err_x   = W'(err);
    assign integ_c = W'(sat_sym(WIDE_W'(integ + KI_X * err_x), WIDE_W'(FSPAN_X)));
    assign f_c     = ACC_W'(clamp_s(WIDE_W'(F0_X + KP_X * err_x + integ_c),
                                    WIDE_W'(F0_X - FSPAN_X), WIDE_W'(F0_X + FSPAN_X)));

    always_ff @(posedge clk) begin
        if (nrst || !enable) begin
            f     <= F0_WORD;
            integ <= '0;
        end else if (err_vld) begin
            f     <= f_c;
            integ <= integ_c;
        end
    end

`ifdef DPLL_LOCK_DETECT_EN
    localparam int LCW = $clog2(LOCK_CNT + 1);

    logic [LCW-1:0] lock_run;
    logic           err_in_tol;

    assign err_in_tol = (err >= -ERR_W'(LOCK_TOL)) && (err <= ERR_W'(LOCK_TOL));

    always_ff @(posedge clk) begin
        if (nrst || !enable) begin
            lock_run <= '0;
            locked   <= 1'b0;
        end else if (err_vld) begin
            if (err_in_tol) begin
                if (lock_run != LCW'(LOCK_CNT)) lock_run <= lock_run + LCW'(1);
                if (lock_run >= LCW'(LOCK_CNT - 1)) locked <= 1'b1;
            end else begin
                // Timeouts are saturated errors, so they always land here.
                lock_run <= '0;
                locked   <= 1'b0;
            end
        end
    end
`else
    localparam int unused_lock_cfg = LOCK_TOL + LOCK_CNT;
    assign locked = 1'b0;
`endif

endmodule
